// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: runs the IDLE/SERVE/PLAY/PAUSE/OVER flow, owns game_state,
// and clears the ball block at the start of each game.
module pong_game_ctrl #(
  parameter int unsigned SERVE_MS  = 1000,
  parameter int unsigned WIN_SCORE = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1ms,
  input  logic       btn_start,
  input  logic       btn_pause,
  input  logic [3:0] p1_score,
  input  logic [3:0] p2_score,
  output logic [1:0] game_state,
  output logic       ball_rst_n,
  output logic [1:0] winner,
  output logic       serving
);

  localparam logic [10:0] SERVE_LOAD = 11'(SERVE_MS);
  localparam logic [3:0]  WIN_LIM    = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SERVE = 3'd1,
    ST_PLAY  = 3'd2,
    ST_PAUSE = 3'd3,
    ST_OVER  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [10:0] serve_cnt_q, serve_cnt_d;
  logic [1:0]  winner_q, winner_d;
  logic        ball_rst_n_q, ball_rst_n_d;
  logic [1:0]  game_state_q, game_state_d;
  logic        serving_q, serving_d;
  logic        start_q, pause_q;
  logic [3:0]  p1_q, p2_q;

  logic start_edge, pause_edge, p1_chg, p2_chg;

  assign start_edge = btn_start & ~start_q;
  assign pause_edge = btn_pause & ~pause_q;
  assign p1_chg     = (p1_score != p1_q);
  assign p2_chg     = (p2_score != p2_q);

  // Button history resets high so a button held through reset never fires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      serve_cnt_q  <= 11'd0;
      winner_q     <= 2'b00;
      ball_rst_n_q <= 1'b0;
      game_state_q <= 2'b00;
      serving_q    <= 1'b0;
      start_q      <= 1'b1;
      pause_q      <= 1'b1;
      p1_q         <= 4'd0;
      p2_q         <= 4'd0;
    end else begin
      state_q      <= state_d;
      serve_cnt_q  <= serve_cnt_d;
      winner_q     <= winner_d;
      ball_rst_n_q <= ball_rst_n_d;
      game_state_q <= game_state_d;
      serving_q    <= serving_d;
      start_q      <= btn_start;
      pause_q      <= btn_pause;
      p1_q         <= p1_score;
      p2_q         <= p2_score;
    end
  end

  always_comb begin
    state_d      = state_q;
    serve_cnt_d  = serve_cnt_q;
    winner_d     = winner_q;
    ball_rst_n_d = ball_rst_n_q;
    case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start_edge) begin
          state_d      = ST_SERVE;
          serve_cnt_d  = SERVE_LOAD;
          winner_d     = 2'b00;
          ball_rst_n_d = 1'b0;
        end else begin
          ball_rst_n_d = 1'b1;
        end
      end
      ST_SERVE: begin
        // The first tick seen here also releases the ball-block clear.
        if (tick_1ms) begin
          serve_cnt_d  = serve_cnt_q - 11'd1;
          ball_rst_n_d = 1'b1;
          if (serve_cnt_q == 11'd1) begin
            state_d = ST_PLAY;
          end else begin
            state_d = ST_SERVE;
          end
        end else begin
          serve_cnt_d = serve_cnt_q;
        end
      end
      ST_PLAY: begin
        if (p1_chg && (p1_score >= WIN_LIM)) begin
          state_d  = ST_OVER;
          winner_d = 2'b01;
        end else if (p2_chg && (p2_score >= WIN_LIM)) begin
          state_d  = ST_OVER;
          winner_d = 2'b10;
        end else if (p1_chg || p2_chg) begin
          state_d     = ST_SERVE;
          serve_cnt_d = SERVE_LOAD;
        end else if (pause_edge) begin
          state_d = ST_PAUSE;
        end else begin
          state_d = ST_PLAY;
        end
      end
      ST_PAUSE: begin
        if (pause_edge) begin
          state_d = ST_PLAY;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    game_state_d = 2'b00;
    serving_d    = 1'b0;
    case (state_d)
      ST_IDLE:  game_state_d = 2'b00;
      ST_PLAY:  game_state_d = 2'b01;
      ST_SERVE: begin
        game_state_d = 2'b10;
        serving_d    = 1'b1;
      end
      ST_PAUSE: game_state_d = 2'b10;
      ST_OVER:  game_state_d = 2'b11;
      default:  game_state_d = 2'b00;
    endcase
  end

  assign game_state = game_state_q;
  assign ball_rst_n = ball_rst_n_q;
  assign winner     = winner_q;
  assign serving    = serving_q;

endmodule

// File: doc/pong_game_ctrl.md
# pong_game_ctrl

Top-level game sequencer for the Pong design. It owns the `game_state` bus that gates ball motion and runs the IDLE → SERVE → PLAY → OVER flow. It also handles pause and clears the ball/score datapath at each new game. It sits between the board buttons and the ball block, watching the scores the ball block reports.

## Interface
- `SERVE_MS`, default 1000: serve delay in `tick_1ms` ticks; range 1..2047.
- `WIN_SCORE`, default 7: score that ends the game; range 1..15.
- `clk` input 1: system clock; the only clock.
- `reset` input 1: synchronous, active-high reset.
- `tick_1ms` input 1: one-`clk`-wide pulse, once per millisecond.
- `btn_start` input 1: start button, level, already debounced.
- `btn_pause` input 1: pause button, level, already debounced.
- `p1_score` input 4: player-1 score from the ball block.
- `p2_score` input 4: player-2 score from the ball block.
- `game_state` output 2: 00 idle, 01 play, 10 serve/pause, 11 game over.
- `ball_rst_n` output 1: active-low clear for the ball block (position and scores).
- `winner` output 2: 00 none, 01 player 1, 10 player 2.
- `serving` output 1: high while in SERVE.

## Operation
- Internal states: IDLE, SERVE, PLAY, PAUSE, OVER.
- State to `game_state` mapping: IDLE→00, PLAY→01, SERVE→10, PAUSE→10, OVER→11.
- Button edges: `btn_start` and `btn_pause` are registered each cycle.
  - An edge is `btn & !btn_q`.
  - `btn_q` registers reset to 1, so a button held through reset never fires.
- Score change: `p1_q`/`p2_q` are registered every cycle in every state.
  - `p1_chg = (p1_score != p1_q)`, and likewise `p2_chg`.
- IDLE / OVER, on start edge:
  - Go to SERVE.
  - Drive `ball_rst_n` low.
  - Load `serve_cnt = SERVE_MS`.
  - Clear `winner` to 00.
- SERVE:
  - Each `tick_1ms` decrements `serve_cnt`.
  - On a tick with `serve_cnt == 1`, go to PLAY.
  - Start and pause edges are ignored.
- PLAY, evaluated in priority order:
  - If `p1_chg` and `p1_score >= WIN_SCORE`: go to OVER, `winner = 01`.
  - Else if `p2_chg` and `p2_score >= WIN_SCORE`: go to OVER, `winner = 10`.
  - Else if any change: go to SERVE and reload `serve_cnt = SERVE_MS`; the ball has already re-centred itself.
  - Else if pause edge: go to PAUSE.
  - The start edge is ignored.
- PAUSE:
  - Pause edge returns to PLAY.
  - Start edge is ignored.
  - Score changes are ignored, since the ball is frozen.
- `ball_rst_n` handshake:
  - Goes low on the start transition.
  - Stays low through the first SERVE cycle in which `tick_1ms` = 1.
  - Goes high on the next cycle, so a ball block clocked by the tick sees at least one reset edge.
  - Scores falling to 0 during this window are absorbed by `p1_q`/`p2_q` and are not evaluated outside PLAY.
- Width rules:
  - `serve_cnt` is 11 bits unsigned.
  - Score compares are 4-bit unsigned.
  - With `WIN_SCORE` ≤ 15, score wrap cannot occur before OVER.

## Timing
- All outputs are registered; a transition taken at edge N is visible after edge N.
- Start to SERVE:
  - Start edge sampled at edge N → `game_state` = 10, `serving` = 1, `ball_rst_n` = 0 after N.
- SERVE duration:
  - Exactly `SERVE_MS` ticks.
  - `game_state` = 01 after the edge that samples the `SERVE_MS`-th tick.
- Score to SERVE/OVER:
  - The score changes at edge M → `p1_chg` is seen in cycle M+1 → state updates at edge M+1.
  - One cycle of latency.
- Reset (any state, any cycle, including mid-serve and mid-`ball_rst_n` window):
  - Next edge: state = IDLE, `game_state` = 00, `winner` = 00, `serving` = 0, `ball_rst_n` = 0, `serve_cnt` = 0.
  - Score registers = 0; button registers = 1.
  - After reset is released: `ball_rst_n` = 1 on the following edge, and the block stays IDLE until a start edge.
- Simultaneous events:
  - Score change plus pause edge in PLAY: the score wins; the pause edge is dropped.
  - Both scores change in one cycle: player 1 is checked first.
  - Tick in the same cycle as the start edge: not counted; counting begins the next cycle.

## Test plan
- Reset with `btn_start` held high, then release reset → stays IDLE; `game_state` = 00, `winner` = 00, `ball_rst_n` = 1 after one cycle.
- `SERVE_MS` = 3, start pulse, ticks every 5 clk:
  - `ball_rst_n` is low until the cycle after the first tick.
  - `game_state` = 10 for 3 ticks, then 01.
- In PLAY, change `p2_score` 0→1 → SERVE one cycle later, counter reloaded, `winner` = 00.
- In PLAY, pause edge → `game_state` 10 and stays there while the scores toggle; a second pause edge → 01.
- `WIN_SCORE` = 7, raise `p1_score` 6→7 in PLAY:
  - → OVER, `game_state` = 11, `winner` = 01.
  - Then a start edge → SERVE with `winner` = 00 and `ball_rst_n` pulsed.
- In PLAY, score change in the same cycle as a pause edge → SERVE, not PAUSE.
- Reset asserted mid-SERVE → IDLE next edge, `serve_cnt` = 0.
